// File: rtl/tmr_array_scrubber_if.sv
`default_nettype none
// ============================================================================
// Interface : tmr_array_scrubber_if
// Brief     : Host write/read request bundle for the TMR array scrubber.
//             master = host side, slave = scrubber controller side.
// Revision  : 1.0 - initial release
// ============================================================================
interface tmr_array_scrubber_if #(
  parameter int M = 4,
  parameter int W = 8
);
  // Write channel: request is held until the one-cycle acknowledge
  logic                 wr_req;
  logic [$clog2(M)-1:0] wr_addr;
  logic [W-1:0]         wr_data;
  logic                 wr_ack;

  // Read channel: request is held until the one-cycle data strobe
  logic                 rd_req;
  logic [$clog2(M)-1:0] rd_addr;
  logic [W-1:0]         rd_data;
  logic                 rd_valid;
  logic                 rd_mismatch;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, rd_data, rd_valid, rd_mismatch
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, rd_data, rd_valid, rd_mismatch
  );
endinterface
`default_nettype wire

// File: rtl/tmr_array_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tmr_array_scrubber
// Brief    : Controller for a triplicated M x W register array. Arbitrates
//            host writes, host reads and a background scrubber that votes
//            one entry per scrub step and rewrites all copies on disagreement.
// Options  : TMR_SCRUB_INJECT_EN - when defined, the inj_* ports XOR a mask
//            into one copy of one entry (fault injection); otherwise unused.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_array_scrubber #(
  parameter int M         = 4,
  parameter int W         = 8,
  parameter int SCRUB_DIV = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 scrub_en,
  tmr_array_scrubber_if.slave  host,
  input  logic                 inj_stb,
  input  logic [1:0]           inj_copy,
  input  logic [$clog2(M)-1:0] inj_addr,
  input  logic [W-1:0]         inj_mask,
  output logic [15:0]          err_cnt,
  output logic                 err_pulse,
  output logic                 pass_done
);

  localparam int c_addr_w = $clog2(M);
  localparam int c_div_w  = $clog2(SCRUB_DIV);
  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(M - 1);
  localparam logic [c_div_w-1:0]  c_div_load  = c_div_w'(SCRUB_DIV - 1);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_CHECK = 3'd3,
    S_FIX   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Three copies (index 0=A, 1=B, 2=C) of the M-entry array
  logic [W-1:0]          r_mem [3][M];
  logic [W-1:0]          w_vote [M];
  logic [M-1:0]          w_mis;

  logic [c_div_w-1:0]    r_div;
  logic [c_addr_w-1:0]   r_scrub_addr;
  logic [c_addr_w-1:0]   r_wr_addr;
  logic [W-1:0]          r_wr_data;
  logic [W-1:0]          r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_mismatch;
  logic [15:0]           r_err_cnt;

  logic                  w_write_en;
  logic [c_addr_w-1:0]   w_write_idx;
  logic [W-1:0]          w_write_val;
  logic                  w_advance;
  logic                  w_wr_start;
  logic                  w_rd_start;
  logic                  w_check_start;

  logic [2:0]            w_inj_sel;
  logic [c_addr_w-1:0]   w_inj_idx;
  logic [W-1:0]          w_inj_xor;

  // Per-entry bitwise majority vote and copy-disagreement flag
  for (genvar e = 0; e < M; e++) begin : g_entry
    assign w_vote[e] = (r_mem[0][e] & r_mem[1][e]) |
                       (r_mem[1][e] & r_mem[2][e]) |
                       (r_mem[0][e] & r_mem[2][e]);
    assign w_mis[e]  = (r_mem[0][e] != r_mem[1][e]) ||
                       (r_mem[1][e] != r_mem[2][e]);
  end

`ifdef TMR_SCRUB_INJECT_EN
  // Decode the injection strobe into a per-copy select (copy 3 = none)
  always_comb begin
    w_inj_sel = '0;
    for (int c = 0; c < 3; c++) begin
      w_inj_sel[c] = inj_stb && (inj_copy == 2'(c));
    end
  end
  assign w_inj_idx = inj_addr;
  assign w_inj_xor = inj_mask;
`else
  logic w_unused_inj;
  assign w_inj_sel    = '0;
  assign w_inj_idx    = '0;
  assign w_inj_xor    = '0;
  assign w_unused_inj = ^{inj_stb, inj_copy, inj_addr, inj_mask};
`endif

  // Arbitration and sequencing: host write > host read > scrub step
  always_comb begin
    w_state_nxt = r_state;
    w_write_en  = 1'b0;
    w_write_idx = r_wr_addr;
    w_write_val = r_wr_data;
    w_advance   = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (host.wr_req)                    w_state_nxt = S_WR;
        else if (host.rd_req)               w_state_nxt = S_RD;
        else if (scrub_en && (r_div == '0)) w_state_nxt = S_CHECK;
      end
      S_WR: begin
        w_write_en  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_RD: begin
        w_state_nxt = S_WAIT;
      end
      S_CHECK: begin
        if (w_mis[r_scrub_addr]) begin
          w_state_nxt = S_FIX;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_FIX: begin
        w_write_en  = 1'b1;
        w_write_idx = r_scrub_addr;
        w_write_val = w_vote[r_scrub_addr];
        w_advance   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  assign w_wr_start    = (r_state == S_WAIT) && (w_state_nxt == S_WR);
  assign w_rd_start    = (r_state == S_WAIT) && (w_state_nxt == S_RD);
  assign w_check_start = (r_state == S_WAIT) && (w_state_nxt == S_CHECK);

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_state_nxt;
  end

  // Copy storage: a write updates all copies and beats a same-entry injection
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int e = 0; e < M; e++) begin
          r_mem[c][e] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        for (int e = 0; e < M; e++) begin
          if (w_write_en && (w_write_idx == c_addr_w'(e))) begin
            r_mem[c][e] <= w_write_val;
          end else if (w_inj_sel[c] && (w_inj_idx == c_addr_w'(e))) begin
            r_mem[c][e] <= r_mem[c][e] ^ w_inj_xor;
          end
        end
      end
    end
  end

  // Scrub divider: reload when disabled or on a scrub step, count down in WAIT
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= c_div_load;
    end else if (!scrub_en || w_check_start) begin
      r_div <= c_div_load;
    end else if ((r_state == S_WAIT) && (r_div != '0)) begin
      r_div <= r_div - 1'b1;
    end
  end

  // Scrub pointer walks the array and wraps to entry 0 after the last one
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_scrub_addr <= '0;
    end else if (w_advance) begin
      r_scrub_addr <= (r_scrub_addr == c_last_addr) ? '0 : r_scrub_addr + 1'b1;
    end
  end

  // Capture the host write at acceptance so the WR cycle commits stable data
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_wr_start) begin
      r_wr_addr <= host.wr_addr;
      r_wr_data <= host.wr_data;
    end
  end

  // Read response: voted data holds between reads, strobe and flag pulse once
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_mismatch <= 1'b0;
    end else begin
      r_rd_valid    <= w_rd_start;
      r_rd_mismatch <= w_rd_start && w_mis[host.rd_addr];
      if (w_rd_start) r_rd_data <= w_vote[host.rd_addr];
    end
  end

  // Corrected-entry counter, saturating at all ones
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if ((r_state == S_FIX) && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign host.wr_ack      = (r_state == S_WR);
  assign host.rd_data     = r_rd_data;
  assign host.rd_valid    = r_rd_valid;
  assign host.rd_mismatch = r_rd_mismatch;
  assign err_cnt          = r_err_cnt;
  assign err_pulse        = (r_state == S_FIX);
  assign pass_done        = w_advance && (r_scrub_addr == c_last_addr);

endmodule
`default_nettype wire
